// File: rtl/seg_scan_driver.sv
// Three-digit time-multiplexed seven-segment scanner with frame-synchronous double buffering,
// optional leading-zero blanking and a global blank.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic [6:0]  ZERO_SEG    = 7'b1000000,
  parameter logic [6:0]  SEG_OFF     = 7'b1111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] d2,
  input  logic [6:0] d1,
  input  logic [6:0] d0,
  input  logic       lzb_en,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       upd_pend,
  output logic       frame
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {StDig0, StDig1, StDig2} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   div_cnt_q;
  logic [6:0]        p2_q, p1_q, p0_q;
  logic [6:0]        s2_q, s1_q, s0_q;

  logic              tick, boundary;
  logic              hide2, hide1, dark;
  logic [6:0]        sel_seg;
  logic [2:0]        sel_an;

  always_comb begin
    tick     = (div_cnt_q == CntW'(REFRESH_DIV - 1));
    boundary = tick && (state_q == StDig2);
    // Tens only blank when hundreds is also a leading zero.
    hide2    = lzb_en && (s2_q == ZERO_SEG);
    hide1    = hide2 && (s1_q == ZERO_SEG);

    state_d  = state_q;
    sel_seg  = SEG_OFF;
    sel_an   = 3'b111;
    dark     = 1'b1;
    unique case (state_q)
      StDig0: begin
        sel_seg = s0_q;
        sel_an  = 3'b110;
        dark    = 1'b0;
        if (tick) state_d = StDig1;
      end
      StDig1: begin
        sel_seg = s1_q;
        sel_an  = 3'b101;
        dark    = hide1;
        if (tick) state_d = StDig2;
      end
      StDig2: begin
        sel_seg = s2_q;
        sel_an  = 3'b011;
        dark    = hide2;
        if (tick) state_d = StDig0;
      end
      default: begin
        state_d = StDig0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      state_q   <= StDig0;
      p2_q      <= SEG_OFF;
      p1_q      <= SEG_OFF;
      p0_q      <= SEG_OFF;
      s2_q      <= SEG_OFF;
      s1_q      <= SEG_OFF;
      s0_q      <= SEG_OFF;
      upd_pend  <= 1'b0;
      frame     <= 1'b0;
      seg       <= SEG_OFF;
      an        <= 3'b111;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + CntW'(1);
      state_q   <= state_d;
      frame     <= boundary;

      if (blank || dark) begin
        seg <= SEG_OFF;
        an  <= 3'b111;
      end else begin
        seg <= sel_seg;
        an  <= sel_an;
      end

      // A load landing on the boundary bypasses the pending buffer.
      if (boundary) begin
        if (load) begin
          s2_q <= d2;
          s1_q <= d1;
          s0_q <= d0;
        end else if (upd_pend) begin
          s2_q <= p2_q;
          s1_q <= p1_q;
          s0_q <= p0_q;
        end
        upd_pend <= 1'b0;
      end else if (load) begin
        p2_q     <= d2;
        p1_q     <= d1;
        p0_q     <= d0;
        upd_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: cycle-count based reference model plus directed
// literal expectations.
module tb_seg_scan_driver;

  localparam int unsigned Div = 4;
  localparam logic [6:0]  Off = 7'h7F;
  localparam logic [6:0]  Zro = 7'h40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [6:0] d2 = 7'h00, d1 = 7'h00, d0 = 7'h00;
  logic       lzb_en = 1'b0;
  logic       blank = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       upd_pend;
  logic       frame;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_driver #(
    .REFRESH_DIV(Div),
    .ZERO_SEG   (Zro),
    .SEG_OFF    (Off)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0),
    .lzb_en  (lzb_en),
    .blank   (blank),
    .seg     (seg),
    .an      (an),
    .upd_pend(upd_pend),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  // Reference model: digit slot and frame boundary derived from the edge count since reset.
  int         mk = 0;
  logic [6:0] ms [3];
  logic [6:0] mp [3];
  logic       mpend = 1'b0;
  logic [6:0] e_seg = Off;
  logic [2:0] e_an = 3'b111;
  logic       e_frame = 1'b0;
  logic       e_pend = 1'b0;
  logic       chk_en = 1'b0;
  logic       watch_a = 1'b0;
  logic       watch_off = 1'b0;

  always @(posedge clk) begin
    int  dig;
    bit  bnd, drk;
    if (rst) begin
      mk = 0;
      mpend = 1'b0;
      for (int i = 0; i < 3; i++) begin
        ms[i] = Off;
        mp[i] = Off;
      end
      e_seg = Off;
      e_an = 3'b111;
      e_frame = 1'b0;
      e_pend = 1'b0;
    end else begin
      dig = (mk / Div) % 3;
      bnd = (mk % (3 * Div)) == (3 * Div - 1);
      drk = blank || (lzb_en && dig == 2 && ms[2] == Zro)
                  || (lzb_en && dig == 1 && ms[2] == Zro && ms[1] == Zro);
      e_seg = drk ? Off : ms[dig];
      e_an = drk ? 3'b111 : ~(3'b001 << dig);
      e_frame = bnd;
      if (bnd) begin
        if (load) begin
          ms[2] = d2; ms[1] = d1; ms[0] = d0;
        end else if (mpend) begin
          ms = mp;
        end
        mpend = 1'b0;
      end else if (load) begin
        mp[2] = d2; mp[1] = d1; mp[0] = d0;
        mpend = 1'b1;
      end
      e_pend = mpend;
      mk++;
    end
    chk_en = 1'b1;
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model seg", int'(seg), int'(e_seg));
      check("model an", int'(an), int'(e_an));
      check("model frame", int'(frame), int'(e_frame));
      check("model upd_pend", int'(upd_pend), int'(e_pend));
      if (watch_a) check("stale A hidden", int'(seg == 7'h12), 0);
      if (watch_off) check("post-reset dark", int'(seg), int'(Off));
    end
  end

  task automatic wait_k(input int t);
    int g = 0;
    while (mk != t && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (mk != t) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_k timeout: got %0d, expected %0d", mk, t);
    end
  endtask

  task automatic do_load(input logic [6:0] a2, input logic [6:0] a1, input logic [6:0] a0);
    d2 = a2; d1 = a1; d0 = a0;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset an", int'(an), 3'b111);
    check("reset seg", int'(seg), int'(Off));
    wait_k(1);
    check("first slot an", int'(an), 3'b110);
    check("first slot seg", int'(seg), int'(Off));
    wait_k(12);
    check("first frame pulse", int'(frame), 1);

    wait_k(13);
    do_load(7'h79, 7'h24, 7'h30);
    check("pending after load", int'(upd_pend), 1);
    check("seg held while pending", int'(seg), int'(Off));
    wait_k(24);
    check("commit frame", int'(frame), 1);
    check("commit clears pend", int'(upd_pend), 0);
    wait_k(25);
    check("units shown", int'(seg), 7'h30);
    check("units an", int'(an), 3'b110);
    wait_k(29);
    check("tens shown", int'(seg), 7'h24);
    check("tens an", int'(an), 3'b101);
    wait_k(33);
    check("hundreds shown", int'(seg), 7'h79);
    check("hundreds an", int'(an), 3'b011);

    wait_k(37);
    do_load(7'h12, 7'h12, 7'h12);
    watch_a = 1'b1;
    wait_k(40);
    do_load(7'h19, 7'h02, 7'h78);
    wait_k(49);
    check("latest load wins", int'(seg), 7'h78);

    wait_k(59);
    do_load(7'h40, 7'h79, 7'h24);
    check("bypass pend stays 0", int'(upd_pend), 0);
    check("bypass frame", int'(frame), 1);
    wait_k(61);
    check("bypass units", int'(seg), 7'h24);
    watch_a = 1'b0;

    wait_k(70);
    lzb_en = 1'b1;
    wait_k(71);
    do_load(Zro, Zro, Zro);
    wait_k(73);
    check("lzb units lit", int'(seg), int'(Zro));
    check("lzb units an", int'(an), 3'b110);
    wait_k(77);
    check("lzb tens dark", int'(an), 3'b111);
    check("lzb tens seg", int'(seg), int'(Off));
    wait_k(81);
    check("lzb hundreds dark", int'(an), 3'b111);

    wait_k(83);
    do_load(Zro, 7'h79, Zro);
    wait_k(85);
    check("lzb2 units", int'(seg), int'(Zro));
    wait_k(89);
    check("lzb2 tens lit", int'(seg), 7'h79);
    check("lzb2 tens an", int'(an), 3'b101);
    wait_k(93);
    check("lzb2 hundreds dark", int'(an), 3'b111);
    wait_k(95);
    lzb_en = 1'b0;

    wait_k(98);
    blank = 1'b1;
    wait_k(99);
    check("blank seg", int'(seg), int'(Off));
    check("blank an", int'(an), 3'b111);
    wait_k(100);
    blank = 1'b0;
    wait_k(101);
    do_load(7'h08, 7'h03, 7'h46);
    check("pending before rst", int'(upd_pend), 1);
    wait_k(105);
    check("no lzb hundreds lit", int'(seg), int'(Zro));
    check("no lzb hundreds an", int'(an), 3'b011);

    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst seg", int'(seg), int'(Off));
    check("rst an", int'(an), 3'b111);
    check("rst pend", int'(upd_pend), 0);
    rst = 1'b0;
    watch_off = 1'b1;
    wait_k(30);
    check("pending discarded", int'(seg), int'(Off));
    watch_off = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed seven-segment scanner sitting directly downstream of the three per-digit seven-segment decoders. It takes the three decoded digit patterns (hundreds, tens, units), double-buffers them so a new value only appears at a frame boundary, and drives one shared segment bus plus three active-low digit enables, cycling one digit per refresh slot. Optional leading-zero blanking and a global blank are included.

## Interface

- REFRESH_DIV, 50000: clock cycles per digit slot; legal range ≥ 2.
- ZERO_SEG, 7'b1000000: segment pattern the decoders emit for digit 0, used for leading-zero detection.
- SEG_OFF, 7'b1111111: segment pattern with all segments dark.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  single-cycle strobe: capture d2/d1/d0.
- d2  input  7  hundreds pattern.
- d1  input  7  tens pattern.
- d0  input  7  units pattern.
- lzb_en  input  1  enable leading-zero blanking.
- blank  input  1  force display dark.
- seg  output  7  shared segment bus, registered.
- an  output  3  digit enables, active-low one-hot, registered; an[0]=units, an[2]=hundreds.
- upd_pend  output  1  captured value waiting for frame boundary.
- frame  output  1  one-cycle pulse after each full scan.

## Operation

- Registers: div_cnt (0..REFRESH_DIV-1), scan state {DIG0, DIG1, DIG2}, pending regs p2/p1/p0 + upd_pend, display regs s2/s1/s0.
- tick = (div_cnt == REFRESH_DIV-1). On tick: div_cnt→0, state DIG0→DIG1→DIG2→DIG0. Otherwise div_cnt+1, state held.
- Frame boundary = cycle where tick and state==DIG2.
- load (non-boundary cycle): p2/p1/p0←d2/d1/d0, upd_pend←1. Repeated load while pending: latest wins.
- Boundary, no load: if upd_pend, s*←p*, upd_pend←0; else s* held.
- Boundary with load: s*←d* directly, upd_pend←0 (bypass; older pending value discarded).
- Leading-zero blanking (lzb_en=1), evaluated on s*: hundreds dark if s2==ZERO_SEG; tens dark if s2==ZERO_SEG and s1==ZERO_SEG; units never blanked by this rule.
- Selected pattern per state: DIG0→s0, an=3'b110; DIG1→s1, an=3'b101; DIG2→s2, an=3'b011. Dark digit or blank=1 → seg=SEG_OFF, an=3'b111.
- Reset values: seg=SEG_OFF, an=3'b111, frame=0, upd_pend=0, div_cnt=0, state=DIG0, s*/p*=SEG_OFF. Reset mid-scan or mid-pending discards all state; no pending value survives.

## Timing

- seg/an registered from current state, s*, blank, lzb_en: one-cycle latency from any of those changing.
- First cycle after rst deasserts: seg=SEG_OFF, an=111; next edge: DIG0 enables (an=110, seg=SEG_OFF since s*=SEG_OFF).
- Each digit active REFRESH_DIV cycles (seen on outputs shifted by one cycle); full frame = 3·REFRESH_DIV cycles.
- frame high exactly one cycle, the cycle after the boundary edge; same cycle new s* first visible internally, visible on seg one cycle later (first DIG0 slot of new frame shows new units).
- load→display latency: ≤ 3·REFRESH_DIV + 1 cycles; upd_pend high from cycle after load until cycle after commit.
- blank/lzb_en: no frame synchronisation; take effect next cycle.

## Test plan

- Reset/scan, REFRESH_DIV=4: release rst -> an sequence 110(4 cyc),101(4),011(4) repeating, seg=7'h7F throughout, frame pulse every 12 cycles.
- Load and commit: load d2=7'h79,d1=7'h24,d0=7'h30 mid-DIG0 -> upd_pend=1, seg unchanged until boundary; next frame shows 7'h30/7'h24/7'h79 on an=110/101/011, upd_pend=0 with frame pulse.
- Double load: load A then load B in same frame -> only B displayed; A never appears.
- Boundary load: load coincident with boundary tick -> value shown in immediately following frame, upd_pend stays 0.
- Leading zeros, lzb_en=1: load 7'h40,7'h40,7'h40 -> only units lit (an=110 slot), other slots an=111; load 7'h40,7'h79,7'h40 -> tens and units lit; lzb_en=0 -> all three lit.
- blank toggled mid-slot and rst asserted with upd_pend=1 -> next cycle seg=7'h7F, an=111; after rst, pending value never displayed.
